// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB command master.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

  // Wait counter width; never below one bit so TIMEOUT=0 still elaborates.
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response and APB signal bundle; master = the bridge, slave = its environment.
interface apb_cmd_master_if import apb_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  PSELx, PENABLE, PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY, PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS wait-state counter; expired flags the edge that hits TIMEOUT.
module apb_timeout_ctr import apb_pkg::*; #(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW     = cnt_w(TIMEOUT);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int SAT_I  = (TIMEOUT > 0) ? TIMEOUT : (1 << CW) - 1;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);
  localparam logic [CW-1:0] SAT  = CW'(SAT_I);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                     cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (enable && cnt != SAT)  cnt <= cnt + 1'b1;

  // cnt holds the wait edges already seen, so LAST means this edge is the TIMEOUT-th.
  assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);
endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB bridge with registered bus/response and wait timeout.
module apb_cmd_master import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_cmd_master_if.master  bus
);
  apb_state_e           state;
  logic                 psel_q, pen_q, pwrite_q;
  logic [ADDR_W-1:0]    paddr_q;
  logic [DATA_W-1:0]    pwdata_q, rdata_q;
  logic [DATA_W/8-1:0]  pstrb_q;
  logic                 rvld_q, rerr_q, rtmo_q;
  logic                 tmo_expired;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (state != ACCESS),
    .enable  (state == ACCESS && !bus.PREADY),
    .expired (tmo_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state    <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rvld_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rtmo_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          // The APB address/data registers double as the latched command.
          psel_q   <= 1'b1;
          pen_q    <= 1'b0;
          pwrite_q <= bus.cmd_write;
          paddr_q  <= bus.cmd_addr;
          pwdata_q <= bus.cmd_wdata;
          pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
          state    <= SETUP;
        end
        SETUP: begin
          pen_q <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (bus.PREADY) begin
          // A completer answering on the timeout edge still wins.
          psel_q  <= 1'b0;
          pen_q   <= 1'b0;
          rvld_q  <= 1'b1;
          rerr_q  <= bus.PSLVERR;
          rtmo_q  <= 1'b0;
          rdata_q <= pwrite_q ? '0 : bus.PRDATA;
          state   <= RESP;
        end else if (tmo_expired) begin
          psel_q  <= 1'b0;
          pen_q   <= 1'b0;
          rvld_q  <= 1'b1;
          rerr_q  <= 1'b1;
          rtmo_q  <= 1'b1;
          rdata_q <= '0;
          state   <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rvld_q  <= 1'b0;
          rerr_q  <= 1'b0;
          rtmo_q  <= 1'b0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = pen_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.rsp_valid   = rvld_q;
  assign bus.rsp_err     = rerr_q;
  assign bus.rsp_timeout = rtmo_q;
  assign bus.rsp_rdata   = rdata_q;
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 32, PADDR/cmd_addr width.
REQ-002 Parameter DATA_W, default 32, data width; strobe width DATA_W/8.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles before abort; 0 disables timeout.
REQ-004 One clock; reset is asynchronous and active-low; ports PCLK and PRESETn.
REQ-005 PCLK  in  1  clock, all state on rising edge.
REQ-006 PRESETn  in  1  async active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address, passed through unmodified.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 cmd_strb  in  DATA_W/8  write byte strobes.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  out  DATA_W  read data, 0 for writes and timeouts.
REQ-016 rsp_err  out  1  PSLVERR or timeout.
REQ-017 rsp_timeout  out  1  transfer aborted by timeout.
REQ-018 PSELx, PENABLE, PWRITE  out  1 each  APB control.
REQ-019 PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
REQ-020 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1  completer response.

Function
REQ-021 FSM states IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-022 cmd_ready = 1 only in IDLE; one outstanding transfer.
REQ-023 IDLE, accept edge: latch command, drive PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB -> SETUP.
REQ-024 SETUP, next edge: PENABLE=1 -> ACCESS; SETUP lasts exactly one cycle.
REQ-025 ACCESS, edge with PREADY=1: PSELx=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA on reads (0 on writes) -> RESP.
REQ-026 ACCESS, edge with PREADY=0: stay, increment wait counter (width clog2(TIMEOUT+1)), saturating.
REQ-027 TIMEOUT>0 and TIMEOUT-th consecutive ACCESS edge with PREADY=0: deassert PSELx/PENABLE, rsp_valid=1, rsp_err=1, rsp_timeout=1 -> RESP.
REQ-028 PREADY=1 on the timeout edge: PREADY wins, normal completion.
REQ-029 PADDR, PWRITE, PWDATA, PSTRB held stable from SETUP through last ACCESS cycle.
REQ-030 PSTRB driven 0 for reads regardless of cmd_strb.
REQ-031 RESP: rsp_* held stable until rsp_ready edge; then rsp_valid=0 -> IDLE.
REQ-032 Min transfer: accept edge to rsp_valid = 2 edges (zero wait states); back-to-back issue period 4 cycles with rsp_ready tied 1.
REQ-033 cmd_* ignored outside IDLE.

Reset
REQ-034 PRESETn low: immediately state=IDLE, PSELx=PENABLE=PWRITE=0, PADDR=PWDATA=PSTRB=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, counter=0.
REQ-035 Reset mid-SETUP/ACCESS aborts the transfer without response; cmd_ready=1 from first edge after release.

Structure
REQ-036 Package apb_pkg holds state enum (IDLE, SETUP, ACCESS, RESP) and default width/timeout constants.
REQ-037 Sub-module apb_timeout_ctr (clear, enable, expired) is natural; FSM and datapath stay in apb_cmd_master.

Verification
REQ-038 Write addr 1, data FFFF_FF00, strb 1111, PREADY=1 -> PSELx high 2 cycles, PENABLE 1 cycle, rsp_err=0, rsp_rdata=0.
REQ-039 Read addr 3, two wait states, PRDATA=5555_5555 -> PSTRB=0, PADDR stable 4 cycles, rsp_rdata=5555_5555, rsp_err=0.
REQ-040 Write addr 12 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-041 PREADY held 0, TIMEOUT=16 -> abort on 16th ACCESS edge, rsp_err=1, rsp_timeout=1; PREADY=1 on that edge -> normal completion.
REQ-042 rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, new cmd_valid ignored.
REQ-043 PRESETn low mid-ACCESS -> PSELx/PENABLE 0 without clock, no rsp_valid, cmd_ready=1 after release.
